// File: rtl/logger_pkg.sv
// logger_pkg: shared types and helpers for the ram_logger capture buffer.
//   state_t : capture FSM state (IDLE/LOG/FULL, binary 0/1/2)
//   clog2   : ceiling log2, used to validate the address width at elaboration
package logger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOG  = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  // Bits needed to represent values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bram_sdp.sv
// bram_sdp: simple dual-port RAM, one write port and one registered read port.
// The array has no reset so synthesis can map it onto block RAM.
// Ports:
//   clock   : clock for both ports
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_re    : read enable (read register holds when low)
//   i_raddr : read address
//   o_rdata : registered read data, valid one cycle after i_raddr
module bram_sdp #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 32000,
  parameter int ADDR_W    = 15
) (
  input  logic                 clock,
  input  logic                 i_we,
  input  logic [ADDR_W-1:0]    i_waddr,
  input  logic [RAM_WIDTH-1:0] i_wdata,
  input  logic                 i_re,
  input  logic [ADDR_W-1:0]    i_raddr,
  output logic [RAM_WIDTH-1:0] o_rdata
);

  logic [RAM_WIDTH-1:0] r_mem [RAM_DEPTH];

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clock) begin
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/ram_logger.sv
// ram_logger: capture buffer for the DSP chain I/Q samples.
// Arms on a rising edge of i_en_log, records one word per i_valid until the
// buffer fills or logging is dropped, then serves single-word readback.
// Ports:
//   clock     : single clock
//   i_reset   : synchronous active-low reset
//   i_en_log  : logging enable level
//   i_valid   : sample strobe
//   i_data    : sample word
//   i_en_read : readback enable
//   i_addr    : readback address
//   o_data    : readback word, one cycle after i_addr (0 when gated)
//   o_count   : words written in the current/last capture
//   o_busy    : high in LOG
//   o_full    : high in FULL
module ram_logger
  import logger_pkg::*;
#(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 32000,
  parameter int ADDR_W    = 15
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic                 i_en_log,
  input  logic                 i_valid,
  input  logic [RAM_WIDTH-1:0] i_data,
  input  logic                 i_en_read,
  input  logic [ADDR_W-1:0]    i_addr,
  output logic [RAM_WIDTH-1:0] o_data,
  output logic [ADDR_W-1:0]    o_count,
  output logic                 o_busy,
  output logic                 o_full
);

  // The count must be able to hold RAM_DEPTH itself.
  if (ADDR_W < clog2(RAM_DEPTH + 1)) begin : g_addr_w_check
    $error("ram_logger: ADDR_W too small for RAM_DEPTH");
  end

  localparam logic [ADDR_W-1:0] LP_DEPTH = ADDR_W'(RAM_DEPTH);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(RAM_DEPTH - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_en_q;      // i_en_log sampled at the edge
  logic                  r_en_qq;     // previous sample, for edge detect
  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [ADDR_W-1:0]     r_count;
  logic                  r_busy;
  logic                  r_full;
  logic                  r_rd_ok;     // gates RAM output onto o_data
  logic                  w_rise;
  logic                  w_we;
  logic                  w_rd_ok;
  logic                  w_busy_nxt;
  logic                  w_full_nxt;
  logic [RAM_WIDTH-1:0]  w_ram_q;

  // Edge detect runs off registered samples, so arming lands one edge after
  // the enable is first seen high.
  assign w_rise = r_en_q & ~r_en_qq;

  // State register plus the registered pointer/count/flags that move with it.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      r_state  <= ST_IDLE;
      r_en_q   <= 1'b0;
      r_en_qq  <= 1'b0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_full   <= 1'b0;
      r_rd_ok  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_en_q  <= i_en_log;
      r_en_qq <= r_en_q;
      r_busy  <= w_busy_nxt;
      r_full  <= w_full_nxt;
      r_rd_ok <= w_rd_ok;
      if (r_state == ST_IDLE && w_rise) begin
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else if (w_we) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_count  <= r_count + 1'b1;
      end
    end
  end

  // Next-state logic. Dropping the enable wins over filling, so a last
  // sample coinciding with the falling edge is written and we land in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_rise) w_state_nxt = ST_LOG;
      ST_LOG: begin
        if (i_valid && r_wr_ptr == LP_LAST) w_state_nxt = ST_FULL;
        if (!i_en_log)                      w_state_nxt = ST_IDLE;
      end
      ST_FULL: if (!i_en_log) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: write strobe, next flag values, read gating.
  always_comb begin
    w_we       = (r_state == ST_LOG) && i_valid;
    w_busy_nxt = (w_state_nxt == ST_LOG);
    w_full_nxt = (w_state_nxt == ST_FULL);
    w_rd_ok    = i_en_read && (r_state != ST_LOG) && (i_addr < LP_DEPTH);
  end

  // Reset suppresses the write on the aborting edge.
  bram_sdp #(
    .RAM_WIDTH (RAM_WIDTH),
    .RAM_DEPTH (RAM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_bram (
    .clock   (clock),
    .i_we    (w_we & i_reset),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_data),
    .i_re    (w_rd_ok),
    .i_raddr (i_addr),
    .o_rdata (w_ram_q)
  );

  // RAM output register plus a registered gate: zero when the read was
  // disabled, out of range, issued during LOG, or after reset.
  assign o_data  = r_rd_ok ? w_ram_q : '0;
  assign o_count = r_count;
  assign o_busy  = r_busy;
  assign o_full  = r_full;

endmodule

// File: tb/tb_ram_logger.sv
module tb_ram_logger;

  logic        clock = 1'b0;
  logic        i_reset;
  logic        i_en_log;
  logic        i_valid;
  logic [31:0] i_data;
  logic        i_en_read;
  logic [14:0] i_addr;
  logic [31:0] o_data;
  logic [14:0] o_count;
  logic        o_busy;
  logic        o_full;

  int n_pass = 0;
  int n_fail = 0;
  int n_tot  = 0;

  ram_logger #(.RAM_WIDTH(32), .RAM_DEPTH(32000), .ADDR_W(15)) dut (
    .clock     (clock),
    .i_reset   (i_reset),
    .i_en_log  (i_en_log),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .i_en_read (i_en_read),
    .i_addr    (i_addr),
    .o_data    (o_data),
    .o_count   (o_count),
    .o_busy    (o_busy),
    .o_full    (o_full)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input int addr, input logic [31:0] exp);
    i_en_read = 1'b1;
    i_addr    = 15'(addr);
    tick();
    chk(tag, o_data, exp);
  endtask

  logic [31:0] short_d [3];

  initial begin
    short_d[0] = 32'h0011_0022;
    short_d[1] = 32'h0033_0044;
    short_d[2] = 32'h0055_0066;

    i_reset = 1'b0; i_en_log = 1'b0; i_valid = 1'b0; i_data = '0;
    i_en_read = 1'b1; i_addr = '0;
    #1;
    repeat (3) tick();
    chk("rst_data",  o_data, 32'h0);
    chk("rst_busy",  32'(o_busy), 32'h0);
    chk("rst_full",  32'(o_full), 32'h0);
    chk("rst_count", 32'(o_count), 32'h0);
    i_reset = 1'b1;
    rd("idle_oob_read", 32000, 32'h0);
    i_en_read = 1'b0;

    // Short capture, arming latency
    i_en_log = 1'b1;
    tick();
    chk("arm_edgeN_busy", 32'(o_busy), 32'h0);
    tick();
    chk("arm_edgeN1_busy", 32'(o_busy), 32'h1);
    chk("arm_count", 32'(o_count), 32'h0);
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1; i_data = short_d[k];
      tick();
      i_valid = 1'b0; i_data = '0;
      repeat (3) tick();
    end
    chk("short_count_log", 32'(o_count), 32'd3);
    i_en_log = 1'b0;
    tick();
    chk("short_busy_off", 32'(o_busy), 32'h0);
    chk("short_count", 32'(o_count), 32'd3);
    rd("short_rd0", 0, short_d[0]);
    rd("short_rd1", 1, short_d[1]);
    rd("short_rd2", 2, short_d[2]);
    i_en_read = 1'b0;

    // Fill to full, data = address, reading addr 5 during LOG
    i_en_log = 1'b1;
    tick(); tick();
    chk("fill_busy", 32'(o_busy), 32'h1);
    i_en_read = 1'b1; i_addr = 15'd5;
    for (int w = 0; w < 32000; w++) begin
      i_valid = 1'b1; i_data = 32'(w);
      tick();
      if (w == 10) chk("log_read_gated_a", o_data, 32'h0);
      if (w == 500) chk("log_read_gated_b", o_data, 32'h0);
      if (w == 31998) begin
        chk("prefull_full", 32'(o_full), 32'h0);
        chk("prefull_count", 32'(o_count), 32'd31999);
      end
    end
    chk("full_flag", 32'(o_full), 32'h1);
    chk("full_busy", 32'(o_busy), 32'h0);
    chk("full_count", 32'(o_count), 32'd32000);
    i_data = 32'hDEAD_BEEF;  // valid stays high: FULL must ignore it
    rd("full_rd_last", 31999, 32'd31999);
    rd("full_rd_oob", 32000, 32'h0);
    rd("full_rd5", 5, 32'd5);
    i_en_read = 1'b0;

    // Re-arm rule: level-high enable in FULL does nothing
    repeat (100) tick();
    chk("hold_full", 32'(o_full), 32'h1);
    chk("hold_count", 32'(o_count), 32'd32000);
    rd("hold_rd0", 0, 32'h0);
    i_en_read = 1'b0;
    i_valid = 1'b0;
    i_en_log = 1'b0;
    tick();
    chk("drop_full", 32'(o_full), 32'h0);
    chk("drop_count_kept", 32'(o_count), 32'd32000);
    i_en_log = 1'b1;
    tick(); tick();
    chk("rearm_busy", 32'(o_busy), 32'h1);
    chk("rearm_count", 32'(o_count), 32'h0);
    // Last sample coincides with enable drop: written, then IDLE
    i_valid = 1'b1; i_data = 32'h0000_A5A5; i_en_log = 1'b0;
    tick();
    i_valid = 1'b0;
    chk("coinc_busy", 32'(o_busy), 32'h0);
    chk("coinc_count", 32'(o_count), 32'd1);
    rd("rearm_rd0", 0, 32'h0000_A5A5);
    rd("rearm_rd1", 1, 32'd1);
    i_en_read = 1'b0;

    // Reset mid-capture
    i_en_log = 1'b1;
    tick(); tick();
    for (int k = 0; k < 10; k++) begin
      i_valid = 1'b1; i_data = 32'h1000 + 32'(k);
      tick();
    end
    chk("mid_count", 32'(o_count), 32'd10);
    i_valid = 1'b1; i_data = 32'h0000_0BAD; i_reset = 1'b0; i_en_log = 1'b0;
    tick();
    chk("midrst_busy", 32'(o_busy), 32'h0);
    chk("midrst_count", 32'(o_count), 32'h0);
    chk("midrst_data", o_data, 32'h0);
    i_reset = 1'b1; i_valid = 1'b0;
    tick();
    chk("midrst_idle", 32'(o_busy), 32'h0);
    rd("midrst_rd9", 9, 32'h0000_1009);
    rd("midrst_rd10", 10, 32'd10);
    i_en_read = 1'b0;
    tick();
    chk("rd_disabled", o_data, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
